// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // 27 MHz board clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 234;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d_i,
  output logic q_o
);

  logic r_s1, r_s2;

  // shift the asynchronous input through two flops
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= d_i;
      r_s2 <= r_s1;
    end
  end

  assign q_o = r_s2;

endmodule

// File: rtl/uart_rx.sv
// Parametrised UART receiver: synchroniser, false-start rejection,
// parity/framing checks and a valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 uart_rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int HALF   = CLKS_PER_BIT / 2 - 1;
  localparam int BITN_W = 4;

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT must be >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_rx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx: STOP_BITS must be 1 or 2");
  end

  logic                 w_rx_s, r_rx_q;
  uart_rx_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [BITN_W-1:0]    r_bitn;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_xor, r_perr_acc, r_ferr_acc;
  logic                 r_busy, r_valid, r_ferr, r_perr, r_ovr;
  logic [DATA_BITS-1:0] r_data;
  logic                 w_tick, w_half;
  logic                 w_cnt_clr, w_bitn_clr, w_begin, w_done;
  logic                 w_data_smp, w_par_smp, w_stop_smp;
  logic                 w_ferr_fin, w_drain;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .d_i      (uart_rx_i),
    .q_o      (w_rx_s)
  );

  assign w_tick = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_half = (r_cnt == CNT_W'(HALF));

  // delayed copy of the synchronised line for falling-edge detection
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_rx_q <= 1'b1;
    else           r_rx_q <= w_rx_s;
  end

  // state register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // next state and per-cycle sampling strobes
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_bitn_clr  = 1'b0;
    w_begin     = 1'b0;
    w_done      = 1'b0;
    w_data_smp  = 1'b0;
    w_par_smp   = 1'b0;
    w_stop_smp  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // only a high-to-low transition starts a frame, so a held-low
        // line (break) cannot retrigger
        if (r_rx_q && !w_rx_s) begin
          w_state_nxt = ST_START;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_START: begin
        if (w_half) begin
          w_cnt_clr = 1'b1;
          if (w_rx_s) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
            w_bitn_clr  = 1'b1;
            w_begin     = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_cnt_clr  = 1'b1;
          w_data_smp = 1'b1;
          if (r_bitn == BITN_W'(DATA_BITS - 1)) begin
            w_bitn_clr  = 1'b1;
            w_state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_cnt_clr   = 1'b1;
          w_par_smp   = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_cnt_clr  = 1'b1;
          w_stop_smp = 1'b1;
          if (r_bitn == BITN_W'(STOP_BITS - 1)) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // bit timing counter, bit index, shift register and error accumulators
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cnt      <= '0;
      r_bitn     <= '0;
      r_shift    <= '0;
      r_xor      <= 1'b0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
    end else begin
      if (w_cnt_clr)                r_cnt <= '0;
      else if (r_state != ST_IDLE)  r_cnt <= r_cnt + 1'b1;

      if (w_bitn_clr)                   r_bitn <= '0;
      else if (w_data_smp || w_stop_smp) r_bitn <= r_bitn + 1'b1;

      if (w_data_smp) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};

      if (w_begin)         r_xor <= 1'b0;
      else if (w_data_smp) r_xor <= r_xor ^ w_rx_s;

      if (w_begin)        r_perr_acc <= 1'b0;
      else if (w_par_smp) r_perr_acc <= (r_xor ^ w_rx_s) != (PARITY == PARITY_ODD);

      if (w_begin)                     r_ferr_acc <= 1'b0;
      else if (w_stop_smp && !w_rx_s)  r_ferr_acc <= 1'b1;
    end
  end

  // the final stop sample is folded in on the completion cycle itself
  assign w_ferr_fin = r_ferr_acc | (w_stop_smp & ~w_rx_s);
  assign w_drain    = r_valid & rx_ready_i;

  // holding register with overrun detection and registered busy flag
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ovr  <= 1'b0;
      r_busy <= (w_state_nxt != ST_IDLE);
      if (w_done) begin
        if (!r_valid || w_drain) begin
          r_data  <= r_shift;
          r_ferr  <= w_ferr_fin;
          r_perr  <= r_perr_acc;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data_o    = r_data;
  assign rx_valid_o   = r_valid;
  assign frame_err_o  = r_ferr;
  assign parity_err_o = r_perr;
  assign overrun_o    = r_ovr;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 receiver at 234 clks/bit and a 7E2 receiver
// at 12 clks/bit, driven with directed and random frames.
module tb_uart_rx;

  localparam int CPB_A = 234;
  localparam int CPB_B = 12;
  localparam int K_A   = 8 + 0 + 1;

  typedef bit bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line_a = 1'b1, line_b = 1'b1;
  logic rdy_a = 1'b1, rdy_b = 1'b1;
  logic [7:0] dat_a;
  logic [6:0] dat_b;
  logic val_a, fe_a, pe_a, ov_a, bz_a;
  logic val_b, fe_b, pe_b, ov_b, bz_b;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  // per-frame observations gathered while driving
  int n_rise, n_ovr, n_busy, rose_cyc;
  logic [8:0] r_dat;
  logic r_fe, r_pe, pv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk_i(clk), .reset_ni(rst_n), .uart_rx_i(line_a),
    .rx_data_o(dat_a), .rx_valid_o(val_a), .rx_ready_i(rdy_a),
    .frame_err_o(fe_a), .parity_err_o(pe_a), .overrun_o(ov_a), .busy_o(bz_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk_i(clk), .reset_ni(rst_n), .uart_rx_i(line_b),
    .rx_data_o(dat_b), .rx_valid_o(val_b), .rx_ready_i(rdy_b),
    .frame_err_o(fe_b), .parity_err_o(pe_b), .overrun_o(ov_b), .busy_o(bz_b)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // wire image of one frame: start, data LSB first, optional parity, stops
  function automatic bq_t mkframe(input int nd, input logic [8:0] w, input int par,
                                  input bit flip, input int nstop, input int lo_stop);
    bq_t q;
    bit p;
    p = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      q.push_back(w[i]);
      p ^= w[i];
    end
    if (par != 0) q.push_back(((par == 1) ? ~p : p) ^ flip);
    for (int s = 0; s < nstop; s++) q.push_back((s == lo_stop) ? 1'b0 : 1'b1);
    return q;
  endfunction

  task automatic sample(input bit sel);
    logic v, fe, pe, ov, bz;
    logic [8:0] d;
    if (sel == 1'b0) {v, fe, pe, ov, bz, d} = {val_a, fe_a, pe_a, ov_a, bz_a, 1'b0, dat_a};
    else             {v, fe, pe, ov, bz, d} = {val_b, fe_b, pe_b, ov_b, bz_b, 2'b0, dat_b};
    if (v && !pv) begin
      n_rise++;
      if (n_rise == 1) begin
        rose_cyc = cyc; r_dat = d; r_fe = fe; r_pe = pe;
      end
    end
    pv = v;
    if (ov) n_ovr++;
    if (bz) n_busy++;
  endtask

  // drive a bit list, cpb cycles per bit, sampling at every falling edge;
  // rdy_edge >= 0 raises ready for exactly the edge t0+rdy_edge
  task automatic drive(input bit sel, input int cpb, input bq_t bits, input int idle,
                       input int rdy_edge, input int maxcyc, output int t0);
    int n;
    n_rise = 0; n_ovr = 0; n_busy = 0; rose_cyc = -1; n = 0;
    @(negedge clk);
    pv = sel ? val_b : val_a;
    t0 = cyc + 1;
    for (int i = 0; i < bits.size() + idle; i++) begin
      if (i < bits.size()) begin
        if (sel) line_b = bits[i]; else line_a = bits[i];
      end else begin
        if (sel) line_b = 1'b1; else line_a = 1'b1;
      end
      repeat ((i < bits.size()) ? cpb : 1) begin
        @(negedge clk);
        sample(sel);
        if (rdy_edge >= 0) begin
          if (cyc + 1 == t0 + rdy_edge) begin
            if (sel) rdy_b = 1'b1; else rdy_a = 1'b1;
          end else if (cyc == t0 + rdy_edge) begin
            if (sel) rdy_b = 1'b0; else rdy_a = 1'b0;
          end
        end
        n++;
        if (maxcyc > 0 && n >= maxcyc) return;
      end
    end
  endtask

  // expected outcome derived from the wire image alone
  task automatic check_frame(input string tag, input int cpb, input bq_t q, input int nd,
                             input int par, input int nstop, input int t0);
    logic [8:0] ed;
    int ones, k;
    bit epe, efe;
    ed = '0; ones = 0; efe = 1'b0;
    for (int i = 0; i < nd; i++) ed[i] = q[1 + i];
    for (int i = 1; i <= nd + ((par != 0) ? 1 : 0); i++) ones += q[i];
    epe = (par == 0) ? 1'b0 : (par == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    for (int i = q.size() - nstop; i < q.size(); i++) if (q[i] == 1'b0) efe = 1'b1;
    k = nd + ((par != 0) ? 1 : 0) + nstop;
    chk({tag, "_nrise"}, n_rise, 1);
    chk({tag, "_when"}, rose_cyc, t0 + 2 + cpb / 2 + k * cpb);
    chk({tag, "_data"}, r_dat, ed);
    chk({tag, "_ferr"}, r_fe, efe);
    chk({tag, "_perr"}, r_pe, epe);
    chk({tag, "_ovr"}, n_ovr, 0);
    chk({tag, "_busy"}, n_busy, cpb / 2 + k * cpb);
  endtask

  initial begin
    bq_t fq, f2;
    int t0;
    logic [8:0] w;
    int lo;
    bit fl;

    repeat (3) @(negedge clk);
    chk("rst_a_val", val_a, 0);
    chk("rst_a_data", dat_a, 0);
    chk("rst_a_busy", bz_a, 0);
    chk("rst_a_errs", {fe_a, pe_a, ov_a}, 0);
    chk("rst_b_val", val_b, 0);
    chk("rst_b_data", dat_b, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 clean frame
    fq = mkframe(8, 9'h05A, 0, 0, 1, -1);
    drive(0, CPB_A, fq, CPB_A, -1, 0, t0);
    check_frame("a_5a", CPB_A, fq, 8, 0, 1, t0);
    chk("a_5a_when_abs", rose_cyc, t0 + 2 + 117 + 9 * 234);

    // stop bit low, line stays low afterwards: no new frame
    fq = mkframe(8, 9'h0C6, 0, 0, 1, 0);
    f2 = fq;
    repeat (2) f2.push_back(1'b0);
    drive(0, CPB_A, f2, CPB_A, -1, 0, t0);
    check_frame("a_ferr", CPB_A, fq, 8, 0, 1, t0);

    // short low glitch: false start
    fq = {};
    fq.push_back(1'b0);
    drive(0, CPB_A / 4, fq, CPB_A, -1, 0, t0);
    chk("glitch_nrise", n_rise, 0);
    chk("glitch_busy", n_busy, CPB_A / 2);
    chk("glitch_val", val_a, 0);

    // back-pressure: second frame overruns
    rdy_a = 1'b0;
    fq = mkframe(8, 9'h011, 0, 0, 1, -1);
    drive(0, CPB_A, fq, CPB_A, -1, 0, t0);
    check_frame("bp_11", CPB_A, fq, 8, 0, 1, t0);
    fq = mkframe(8, 9'h022, 0, 0, 1, -1);
    drive(0, CPB_A, fq, CPB_A, -1, 0, t0);
    chk("ovr_count", n_ovr, 1);
    chk("ovr_held", dat_a, 8'h11);
    chk("ovr_val", val_a, 1);
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    chk("drain_val", val_a, 0);
    chk("drain_data", dat_a, 8'h11);

    // ready asserted exactly on the completion edge: replace, no overrun
    fq = mkframe(8, 9'h011, 0, 0, 1, -1);
    drive(0, CPB_A, fq, CPB_A, -1, 0, t0);
    check_frame("bp2_11", CPB_A, fq, 8, 0, 1, t0);
    fq = mkframe(8, 9'h022, 0, 0, 1, -1);
    drive(0, CPB_A, fq, CPB_A, 2 + CPB_A / 2 + K_A * CPB_A, 0, t0);
    chk("sim_ovr", n_ovr, 0);
    chk("sim_data", dat_a, 8'h22);
    chk("sim_val", val_a, 1);
    rdy_a = 1'b1;
    @(negedge clk);
    chk("sim_drain", val_a, 0);

    // reset during data bit 3 with a word held
    rdy_a = 1'b0;
    fq = mkframe(8, 9'h0A5, 0, 0, 1, -1);
    drive(0, CPB_A, fq, CPB_A, -1, 0, t0);
    check_frame("pre_rst", CPB_A, fq, 8, 0, 1, t0);
    fq = mkframe(8, 9'h0B7, 0, 0, 1, -1);
    drive(0, CPB_A, fq, 0, -1, 4 * CPB_A + CPB_A / 2, t0);
    chk("mid_busy", bz_a, 1);
    rst_n = 1'b0;
    line_a = 1'b1;
    #1;
    chk("mrst_val", val_a, 0);
    chk("mrst_data", dat_a, 0);
    chk("mrst_busy", bz_a, 0);
    chk("mrst_errs", {fe_a, pe_a, ov_a}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rdy_a = 1'b1;
    repeat (3) @(negedge clk);
    fq = mkframe(8, 9'h0C3, 0, 0, 1, -1);
    drive(0, CPB_A, fq, CPB_A, -1, 0, t0);
    check_frame("post_c3", CPB_A, fq, 8, 0, 1, t0);

    // random 8N1 frames, occasional bad stop bit
    for (int r = 0; r < 3; r++) begin
      w  = 9'($urandom_range(0, 255));
      lo = ($urandom_range(0, 2) == 0) ? 0 : -1;
      fq = mkframe(8, w, 0, 0, 1, lo);
      drive(0, CPB_A, fq, CPB_A, -1, 0, t0);
      check_frame($sformatf("a_rnd%0d", r), CPB_A, fq, 8, 0, 1, t0);
    end

    // 7E2: good parity, then flipped parity
    fq = mkframe(7, 9'h041, 2, 0, 2, -1);
    drive(1, CPB_B, fq, CPB_B, -1, 0, t0);
    check_frame("b_41_ok", CPB_B, fq, 7, 2, 2, t0);
    chk("b_41_pe0", r_pe, 0);
    fq = mkframe(7, 9'h041, 2, 1, 2, -1);
    drive(1, CPB_B, fq, CPB_B, -1, 0, t0);
    check_frame("b_41_bad", CPB_B, fq, 7, 2, 2, t0);
    chk("b_41_pe1", r_pe, 1);
    chk("b_41_data", r_dat, 9'h041);

    // random 7E2 frames with random parity and stop faults
    for (int r = 0; r < 10; r++) begin
      w  = 9'($urandom_range(0, 127));
      fl = ($urandom_range(0, 2) == 0);
      lo = int'($urandom_range(0, 3)) - 2;
      fq = mkframe(7, w, 2, fl, 2, lo);
      drive(1, CPB_B, fq, CPB_B, -1, 0, t0);
      check_frame($sformatf("b_rnd%0d", r), CPB_B, fq, 7, 2, 2, t0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
